rom_loader: RTL and testbench

//  Writer side of the 16-bit instruction ROM. The CPU only reads the ROM; this block fills it.

---
 rtl/rom_loader.sv | 203 ++++++++++++++++++++
 tb/tb_rom_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: writer side of the 16-bit instruction ROM.
// Takes a byte stream (LEN_HI, LEN_LO, then N big-endian {HI, LO} word pairs) and writes the
// words to ROM addresses 0..N-1. It is meant to run while the CPU is held in reset. When the
// load finishes it pulses done_o, and the CPU can then be released.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN. When it is defined, a trailing XOR checksum
// byte follows the data, and a mismatch sets err_o.
//
// Handshake: a byte transfers on a rising edge where in_valid_i && in_ready_o. in_ready_o is
// decoded from the registered state only. It never depends on in_valid_i, and it stays high in
// every byte-consuming state whether or not a byte arrives. in_valid_i may drop at any time
// without losing or repeating a byte.
module rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_byte_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        dbg_state_o
);

  // The word is always two bytes, and the 16-bit word index must be able to drive the address.
  if (DATA_W != 16 || ADDR_W < 1 || ADDR_W > 16) begin : g_bad_params
    $error("rom_loader: DATA_W must be 16 and ADDR_W must be in 1..16");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_t;

  // After the last data byte, go to the checksum byte if there is one, otherwise finish.
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         idx_q, idx_d;
  logic [7:0]          hi_q, hi_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                xfer;
  logic                done_c;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
  logic                err_q, err_d;
`endif

  assign xfer = in_valid_i && in_ready_o;

  // The ready output is a decode of the registered state: high in every byte-consuming state.
  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: in_ready_o = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK:                                  in_ready_o = 1'b1;
`endif
      default:                                in_ready_o = 1'b0;
    endcase
  end

  // Next-state logic: byte sequencing, word assembly, write strobe and the done pulse.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_c  = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    err_d   = err_q;
    if (xfer && state_q != S_CHK) chk_d = chk_q ^ in_byte_i;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          busy_d  = 1'b1;
          idx_d   = 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
          chk_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_byte_i;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_byte_i;
          state_d    = ({len_q[15:8], in_byte_i} == 16'd0) ? S_AFTER_DATA : S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (xfer) begin
          hi_d    = in_byte_i;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {hi_q, in_byte_i};
          idx_d   = idx_q + 16'd1;
          state_d = ((idx_q + 16'd1) == len_q) ? S_AFTER_DATA : S_DAT_HI;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          err_d   = (in_byte_i != chk_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // The final write is still on the bus in its strobe cycle. Hold done off until the
        // strobe has dropped, so the two never overlap.
        if (!we_q) begin
          done_c  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts a load at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_c;
  assign dbg_state_o = state_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader.
// It drives one 15-bit-address instance and one 2-bit-address instance; the 2-bit one covers
// address wrap. Both instances share the byte stream, and only the selected one gets start.
`timescale 1ns/1ps
module tb_rom_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        start_a, start_b, in_valid, sel;
  logic [7:0]  in_byte;

  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic [14:0] a_addr;
  logic [15:0] a_wdata;
  logic [2:0]  a_state;
  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata;
  logic [2:0]  b_state;

  rom_loader #(.ADDR_W(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .in_valid_i(in_valid), .in_byte_i(in_byte),
    .in_ready_o(a_ready), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .dbg_state_o(a_state)
  );

  rom_loader #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .in_valid_i(in_valid), .in_byte_i(in_byte),
    .in_ready_o(b_ready), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .dbg_state_o(b_state)
  );

  logic        cur_ready, cur_we, cur_busy, cur_done, cur_err;
  logic [14:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [2:0]  cur_state;
  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_we    = sel ? b_we    : a_we;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_done  = sel ? b_done  : a_done;
  assign cur_err   = sel ? b_err   : a_err;
  assign cur_addr  = sel ? {13'd0, b_addr} : a_addr;
  assign cur_wdata = sel ? b_wdata : a_wdata;
  assign cur_state = sel ? b_state : a_state;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];          // {addr[14:0], data[15:0]}
  logic [15:0] wbuf[16];
  int cyc = 0;
  int last_we_cyc = -10;
  logic prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every ROM write is matched against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && cur_we) begin
      check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      check("we_done_exclusive", {31'd0, cur_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {17'd0, cur_addr}, 32'hFFFF_FFFF);
      end else begin
        check("write_addr", {17'd0, cur_addr}, {17'd0, exp_q[0][30:16]});
        check("write_data", {16'd0, cur_wdata}, {16'd0, exp_q[0][15:0]});
        void'(exp_q.pop_front());
      end
      last_we_cyc = cyc;
    end
    prev_we = rst_n && cur_we;
  end

  // ---------------- driver tasks ----------------
  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic pulse_start();
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check("busy_after_start", {31'd0, cur_busy}, 32'd1);
    check("ready_in_len_hi", {31'd0, cur_ready}, 32'd1);
    check("err_cleared_by_start", {31'd0, cur_err}, 32'd0);
  endtask

  // Offer one byte until it is taken, then idle the bus for gap cycles. During those cycles the
  // DUT is still mid-frame, so it must keep ready high.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!cur_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("ready_timeout", waited, 0);
    @(posedge clk); #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_byte  = 8'(~b);
      for (int g = 0; g < gap; g++) begin
        check("ready_held_in_gap", {31'd0, cur_ready}, 32'd1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input logic exp_err, input bit check_lat);
    int w = 0;
    while (!cur_done && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("done_seen", {31'd0, cur_done}, 32'd1);
    check("err_with_done", {31'd0, cur_err}, {31'd0, exp_err});
    check("busy_during_done", {31'd0, cur_busy}, 32'd1);
    check("all_writes_seen", exp_q.size(), 0);
    if (check_lat) check("done_after_last_write", cyc - last_we_cyc, 1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, cur_done}, 32'd0);
    check("busy_falls", {31'd0, cur_busy}, 32'd0);
    check("state_idle", {29'd0, cur_state}, 32'd0);
    check("err_sticky", {31'd0, cur_err}, {31'd0, exp_err});
  endtask

  // Send a complete frame of n words from wbuf. The checksum model XORs every byte the bench
  // sends from LEN_HI up to the last LO byte.
  task automatic load(input int n, input int gap, input int amask, input logic [7:0] chk_flip,
                      input bit mid_start);
    logic [7:0]  chk;
    logic [15:0] nb;
    logic [14:0] last_addr;
    nb        = 16'(n);
    chk       = nb[15:8] ^ nb[7:0];
    last_addr = '0;
    pulse_start();
    send_byte(nb[15:8], gap);
    send_byte(nb[7:0], (n == 0 && !CK) ? 0 : gap);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == 2) set_start(1'b1);
      if (mid_start && i == 3) set_start(1'b0);
      last_addr = 15'(i & amask);
      exp_q.push_back({last_addr, wbuf[i]});
      chk = chk ^ wbuf[i][15:8] ^ wbuf[i][7:0];
      send_byte(wbuf[i][15:8], gap);
      send_byte(wbuf[i][7:0], (i == n - 1 && !CK) ? 0 : gap);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(chk ^ chk_flip, 0);
    in_valid = 1'b0;
    wait_done(chk_flip != 8'd0, 1'b0);
`else
    in_valid = 1'b0;
    wait_done(1'b0, n > 0);
`endif
    if (n > 0) begin
      check("addr_holds", {17'd0, cur_addr}, {17'd0, last_addr});
      check("wdata_holds", {16'd0, cur_wdata}, {16'd0, wbuf[n-1]});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_byte = 8'h00;
    #12;
    check("rst_ready", {31'd0, cur_ready}, 32'd0);
    check("rst_we", {31'd0, cur_we}, 32'd0);
    check("rst_addr", {17'd0, cur_addr}, 32'd0);
    check("rst_wdata", {16'd0, cur_wdata}, 32'd0);
    check("rst_busy", {31'd0, cur_busy}, 32'd0);
    check("rst_done", {31'd0, cur_done}, 32'd0);
    check("rst_err", {31'd0, cur_err}, 32'd0);
    check("rst_state", {29'd0, cur_state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered in IDLE without start are not taken.
    in_valid = 1'b1; in_byte = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_low", {31'd0, cur_ready}, 32'd0);
    check("idle_no_busy", {31'd0, cur_busy}, 32'd0);
    check("idle_state", {29'd0, cur_state}, 32'd0);
    in_valid = 1'b0;

    // Test 1: two words, back to back.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    load(2, 0, 32'h7FFF, 8'h00, 1'b0);

    // Test 2: empty frame.
    load(0, 0, 32'h7FFF, 8'h00, 1'b0);

    // Test 3: same frame, with in_valid toggling every cycle.
    load(2, 1, 32'h7FFF, 8'h00, 1'b0);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Test 4: a good checksum, then a bad one, then confirm err is sticky until the next start.
    wbuf[0] = 16'hBEEF;
    load(1, 0, 32'h7FFF, 8'h00, 1'b0);
    load(1, 0, 32'h7FFF, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky_idle", {31'd0, cur_err}, 32'd1);
    load(1, 0, 32'h7FFF, 8'h00, 1'b0);
`endif

    // Random data with a random inter-byte gap.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom_range(0, 65535));
    load(4, $urandom_range(0, 2), 32'h7FFF, 8'h00, 1'b0);

    // Test 5: reset arrives after the third data byte of a 3-word frame.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    exp_q.push_back({15'd0, 16'h1122});
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, cur_ready}, 32'd0);
    check("async_rst_we", {31'd0, cur_we}, 32'd0);
    check("async_rst_addr", {17'd0, cur_addr}, 32'd0);
    check("async_rst_wdata", {16'd0, cur_wdata}, 32'd0);
    check("async_rst_busy", {31'd0, cur_busy}, 32'd0);
    check("async_rst_state", {29'd0, cur_state}, 32'd0);
    check("only_first_word_written", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wbuf[0] = 16'h5A5A; wbuf[1] = 16'hC3C3;
    load(2, 0, 32'h7FFF, 8'h00, 1'b0);

    // Test 6: 2-bit address instance, 5 words, with start pulsed mid-load.
    sel = 1'b1;
    for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom_range(0, 65535));
    load(5, 0, 3, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("mid_start_ignored", {29'd0, cur_state}, 32'd0);
    sel = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
